// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
//   ALU control sequencer. Decodes a funct code offered with a valid strobe
//   and drives registered control to the ALU, shifter, divider and result
//   MUX. Single-cycle ops complete one cycle after acceptance. DIVU (and
//   MULTU when ALU_CTRL_MULT_EN is defined) run an iteration counter, then
//   pulse the HiLo write together with op_done.
//
//   Optional feature macro: ALU_CTRL_MULT_EN (adds MULTU / MUL_RUN).
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-high reset
//     funct      in   function code
//     valid      in   funct valid; sampled only while busy=0
//     busy       out  multicycle op in progress
//     alu_op     out  ALU operation encoding
//     sht_en     out  shifter enable (sll)
//     div_start  out  one-cycle divider (or multiplier) start pulse
//     div_en     out  divider (or multiplier) iterating
//     hilo_we    out  one-cycle HiLo write pulse
//     mux_sel    out  result source 0=ALU 1=SHT 2=HI 3=LO
//     op_done    out  one-cycle completion pulse
//     illegal    out  one-cycle pulse with op_done for an undecoded funct
//
//   state   | meaning
//   IDLE    | ready; decodes funct when valid
//   DIV_RUN | divider iterating, counting up to DIV_CYCLES
//   MUL_RUN | multiplier iterating, counting up to MULT_CYCLES (macro only)
//   HILO_WR | last cycle of a multicycle op; next edge pulses hilo_we/op_done

module alu_ctrl_seq #(
  parameter int FUNCT_W     = 6,
  parameter int OP_W        = 3,
  parameter int DIV_CYCLES  = 32,
  parameter int MULT_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               valid,
  output logic               busy,
  output logic [OP_W-1:0]    alu_op,
  output logic               sht_en,
  output logic               div_start,
  output logic               div_en,
  output logic               hilo_we,
  output logic [1:0]         mux_sel,
  output logic               op_done,
  output logic               illegal
);

  if (DIV_CYCLES < 1 || MULT_CYCLES < 1) begin : g_bad_cfg
    $error("alu_ctrl_seq: DIV_CYCLES and MULT_CYCLES must be >= 1");
  end

`ifdef ALU_CTRL_MULT_EN
  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
`else
  localparam int CNT_MAX = DIV_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(DIV_CYCLES);
`ifdef ALU_CTRL_MULT_EN
  localparam logic [CNT_W-1:0] MUL_TC = CNT_W'(MULT_CYCLES);
`endif

  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(16);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(18);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(25);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(27);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(32);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(34);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(36);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(37);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(42);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'b010);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3'b110);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3'b000);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3'b001);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(3'b111);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    HILO_WR = 2'd2
`ifdef ALU_CTRL_MULT_EN
    , MUL_RUN = 2'd3
`endif
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic            busy_n, sht_en_n, div_start_n, div_en_n, hilo_we_n;
  logic            op_done_n, illegal_n;
  logic [OP_W-1:0] alu_op_n;
  logic [1:0]      mux_sel_n;

  // All outputs are registered from the next-cycle values computed here,
  // so every pulse lasts exactly one cycle unless re-asserted.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    busy_n      = 1'b0;
    alu_op_n    = '0;
    sht_en_n    = 1'b0;
    div_start_n = 1'b0;
    div_en_n    = 1'b0;
    hilo_we_n   = 1'b0;
    mux_sel_n   = 2'd0;
    op_done_n   = 1'b0;
    illegal_n   = 1'b0;

    case (state)
      IDLE: begin
        if (valid) begin
          case (funct)
            F_ADD: begin alu_op_n = OP_ADD; op_done_n = 1'b1; end
            F_SUB: begin alu_op_n = OP_SUB; op_done_n = 1'b1; end
            F_AND: begin alu_op_n = OP_AND; op_done_n = 1'b1; end
            F_OR:  begin alu_op_n = OP_OR;  op_done_n = 1'b1; end
            F_SLT: begin alu_op_n = OP_SLT; op_done_n = 1'b1; end
            F_SLL: begin
              sht_en_n  = 1'b1;
              mux_sel_n = 2'd1;
              op_done_n = 1'b1;
            end
            F_MFHI: begin mux_sel_n = 2'd2; op_done_n = 1'b1; end
            F_MFLO: begin mux_sel_n = 2'd3; op_done_n = 1'b1; end
            F_DIVU: begin
              div_start_n = 1'b1;
              div_en_n    = 1'b1;
              busy_n      = 1'b1;
              cnt_n       = CNT_W'(1);
              state_n     = DIV_RUN;
            end
`ifdef ALU_CTRL_MULT_EN
            F_MULTU: begin
              div_start_n = 1'b1;
              div_en_n    = 1'b1;
              busy_n      = 1'b1;
              cnt_n       = CNT_W'(1);
              state_n     = MUL_RUN;
            end
`endif
            default: begin
              illegal_n = 1'b1;
              op_done_n = 1'b1;
            end
          endcase
        end
      end

      DIV_RUN: begin
        busy_n = 1'b1;
        if (cnt == DIV_TC) begin
          cnt_n   = '0;
          state_n = HILO_WR;
        end else begin
          cnt_n    = cnt + CNT_W'(1);
          div_en_n = 1'b1;
        end
      end

`ifdef ALU_CTRL_MULT_EN
      MUL_RUN: begin
        busy_n = 1'b1;
        if (cnt == MUL_TC) begin
          cnt_n   = '0;
          state_n = HILO_WR;
        end else begin
          cnt_n    = cnt + CNT_W'(1);
          div_en_n = 1'b1;
        end
      end
`endif

      HILO_WR: begin
        hilo_we_n = 1'b1;
        op_done_n = 1'b1;
        state_n   = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // F_MULTU is only decoded with the multiplier; keep it referenced so the
  // default build has no dangling constant.
  logic unused_multu;
  assign unused_multu = (F_MULTU == funct) & 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      alu_op    <= '0;
      sht_en    <= 1'b0;
      div_start <= 1'b0;
      div_en    <= 1'b0;
      hilo_we   <= 1'b0;
      mux_sel   <= 2'd0;
      op_done   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      alu_op    <= alu_op_n;
      sht_en    <= sht_en_n;
      div_start <= div_start_n;
      div_en    <= div_en_n;
      hilo_we   <= hilo_we_n;
      mux_sel   <= mux_sel_n;
      op_done   <= op_done_n;
      illegal   <= illegal_n;
    end
  end

endmodule
